qspi_device_interface: RTL and testbench

- Device-mode (peripheral-side) SPI/QSPI-style single-lane transceiver, MSB first.
- Receives bytes on spi_mosi and drives spi_miso, using externally supplied SCK and CS_N that are asynchronous to clk. All three inputs are oversampled and synchronized into clk.
- Sits under bridge or register-file logic that exposes internal state to an external host, such as a debug MCU or a host FPGA.
- Parent logic supplies transmit bytes through a one-deep holding buffer and consumes received bytes as single-cycle valid pulses.

---
 rtl/qspi_device_interface_if.sv | 25 ++
 rtl/qspi_device_interface.sv | 171 +++++++++++++++++
 tb/tb_qspi_device_interface.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_device_interface_if.sv
// Parent-side byte interface of the SPI device transceiver.
// Handshake: tx_load is a one-cycle write strobe into a one-deep holding
// buffer; tx_req, rx_valid, start and stop are one-cycle pulses with no
// back-pressure. rx_data is held stable between rx_valid pulses.
// active mirrors the transceiver state (1 while a chip-select frame is open).
interface qspi_device_interface_if;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_req;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       start;
   logic       stop;
   logic       active;

   modport master (
      output tx_data, tx_load,
      input  tx_req, rx_data, rx_valid, start, stop, active
   );

   modport slave (
      input  tx_data, tx_load,
      output tx_req, rx_data, rx_valid, start, stop, active
   );
endinterface

// File: rtl/qspi_device_interface.sv
// Device-side single-lane SPI transceiver, MSB first. SCK, CS_N and MOSI are
// oversampled in the clk domain; clk must run at least 8x the SCK rate.
module qspi_device_interface #(
   parameter string SAMPLE_EDGE = "RISING",
   parameter int    SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_sck,
   input  logic spi_cs_n,
   input  logic spi_mosi,
   output logic spi_miso,
   output logic spi_miso_oe,
   qspi_device_interface_if.slave bus
);

   generate
      if (SAMPLE_EDGE != "RISING" && SAMPLE_EDGE != "FALLING") begin : g_bad_edge
         $fatal(1, "SAMPLE_EDGE must be RISING or FALLING");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $fatal(1, "SYNC_STAGES must be at least 2");
      end
   endgenerate

   localparam bit   IS_RISING = (SAMPLE_EDGE == "RISING");
   localparam logic SCK_IDLE  = IS_RISING ? 1'b0 : 1'b1;

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
   logic sck_d, cs_d;
   logic sck_s, cs_s, mosi_s;
   logic sck_rise, sck_fall, cs_rise, cs_fall;
   logic sample_edge, shift_edge;
   logic do_start, do_stop, do_sample, do_shift;

   logic [7:0] tx_buf, tx_shreg, rx_shreg, rx_data_q;
   logic [2:0] bit_count;
   logic       miso_q, oe_q, tx_req_q, rx_valid_q, start_q, stop_q;

   // Input synchronizers plus one delay flop each on sck and cs_n for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
         cs_sync   <= '1;
         mosi_sync <= '0;
         sck_d     <= SCK_IDLE;
         cs_d      <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sck_d     <= sck_sync[SYNC_STAGES-1];
         cs_d      <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s       = sck_sync[SYNC_STAGES-1];
   assign cs_s        = cs_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign sck_rise    = sck_s & ~sck_d;
   assign sck_fall    = ~sck_s & sck_d;
   assign cs_rise     = cs_s & ~cs_d;
   assign cs_fall     = ~cs_s & cs_d;
   assign sample_edge = IS_RISING ? sck_rise : sck_fall;
   assign shift_edge  = IS_RISING ? sck_fall : sck_rise;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and per-cycle datapath commands; SCK edges coinciding with CS_N rising are dropped.
   always_comb begin
      state_d   = state_q;
      do_start  = 1'b0;
      do_stop   = 1'b0;
      do_sample = 1'b0;
      do_shift  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d  = ACTIVE;
               do_start = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d = IDLE;
               do_stop = 1'b1;
            end else begin
               do_sample = sample_edge;
               do_shift  = shift_edge;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Shift registers, holding buffer, bit counter and registered pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_buf     <= 8'h00;
         tx_shreg   <= 8'h00;
         rx_shreg   <= 8'h00;
         rx_data_q  <= 8'h00;
         bit_count  <= 3'd0;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
         tx_req_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         tx_req_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         // A reload in this same cycle still reads the old tx_buf.
         if (bus.tx_load) tx_buf <= bus.tx_data;
         if (do_start) begin
            start_q   <= 1'b1;
            bit_count <= 3'd0;
            tx_shreg  <= tx_buf;
            miso_q    <= tx_buf[7];
            oe_q      <= 1'b1;
            tx_req_q  <= 1'b1;
         end
         if (do_stop) begin
            stop_q    <= 1'b1;
            oe_q      <= 1'b0;
            miso_q    <= 1'b0;
            bit_count <= 3'd0;
         end
         if (do_sample) begin
            rx_shreg <= {rx_shreg[6:0], mosi_s};
            if (bit_count == 3'd7) begin
               rx_data_q  <= {rx_shreg[6:0], mosi_s};
               rx_valid_q <= 1'b1;
               bit_count  <= 3'd0;
            end else begin
               bit_count <= bit_count + 3'd1;
            end
         end
         if (do_shift) begin
            if (bit_count == 3'd0) begin
               tx_shreg <= tx_buf;
               miso_q   <= tx_buf[7];
               tx_req_q <= 1'b1;
            end else begin
               miso_q   <= tx_shreg[6];
               tx_shreg <= {tx_shreg[6:0], 1'b0};
            end
         end
      end
   end

   assign spi_miso     = miso_q;
   assign spi_miso_oe  = oe_q;
   assign bus.tx_req   = tx_req_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.start    = start_q;
   assign bus.stop     = stop_q;
   assign bus.active   = (state_q == ACTIVE);

endmodule

// File: tb/tb_qspi_device_interface.sv
// Bench for qspi_device_interface: one RISING and one FALLING instance,
// driven by a bit-level SPI host with randomized traffic.
module tb_qspi_device_interface;
   localparam int SYNC = 2;
   localparam int HALF = 8;   // clk cycles per SCK half period

   // Clock and reset.
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic sck_r, cs_r, mosi_r, miso_r, oe_r;
   logic sck_f, cs_f, mosi_f, miso_f, oe_f;

   qspi_device_interface_if bus_r ();
   qspi_device_interface_if bus_f ();

   qspi_device_interface #(.SAMPLE_EDGE("RISING"), .SYNC_STAGES(SYNC)) dut_r (
      .clk(clk), .rst_n(rst_n), .spi_sck(sck_r), .spi_cs_n(cs_r), .spi_mosi(mosi_r),
      .spi_miso(miso_r), .spi_miso_oe(oe_r), .bus(bus_r.slave)
   );

   qspi_device_interface #(.SAMPLE_EDGE("FALLING"), .SYNC_STAGES(SYNC)) dut_f (
      .clk(clk), .rst_n(rst_n), .spi_sck(sck_f), .spi_cs_n(cs_f), .spi_mosi(mosi_f),
      .spi_miso(miso_f), .spi_miso_oe(oe_f), .bus(bus_f.slave)
   );

   // Scoreboard state.
   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];
   int n_start[2], n_stop[2], n_txreq[2], n_rx[2];
   logic [7:0] tx_buf_m[2];
   logic [7:0] last_rx_m[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pulse monitor and received-byte scoreboard, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus_r.start)  n_start[0]++;
      if (bus_r.stop)   n_stop[0]++;
      if (bus_r.tx_req) n_txreq[0]++;
      if (bus_f.start)  n_start[1]++;
      if (bus_f.stop)   n_stop[1]++;
      if (bus_f.tx_req) n_txreq[1]++;
      if (bus_r.rx_valid) begin
         n_rx[0]++;
         check_eq("rx_expected_r", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check_eq("rx_data_r", bus_r.rx_data, exp_q.pop_front());
      end
      if (bus_f.rx_valid) begin
         n_rx[1]++;
         check_eq("rx_expected_f", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check_eq("rx_data_f", bus_f.rx_data, exp_q.pop_front());
      end
   end

   // Pin driver tasks.
   task automatic set_sck(input bit fm, input logic v);
      if (fm) sck_f = v; else sck_r = v;
   endtask
   task automatic set_cs(input bit fm, input logic v);
      if (fm) cs_f = v; else cs_r = v;
   endtask
   task automatic set_mosi(input bit fm, input logic v);
      if (fm) mosi_f = v; else mosi_r = v;
   endtask
   function automatic logic get_miso(input bit fm);
      return fm ? miso_f : miso_r;
   endfunction
   function automatic logic get_oe(input bit fm);
      return fm ? oe_f : oe_r;
   endfunction
   function automatic logic [7:0] get_rx(input bit fm);
      return fm ? bus_f.rx_data : bus_r.rx_data;
   endfunction

   // One-cycle tx_load strobe; called at a negedge, returns one negedge later.
   task automatic load_tx(input bit fm, input logic [7:0] v);
      if (fm) begin bus_f.tx_data = v; bus_f.tx_load = 1'b1; end
      else    begin bus_r.tx_data = v; bus_r.tx_load = 1'b1; end
      @(negedge clk);
      bus_f.tx_load = 1'b0;
      bus_r.tx_load = 1'b0;
      tx_buf_m[fm] = v;
   endtask

   // Host transaction: n_bytes full bytes then `extra` bits, then CS_N high.
   // load_mode 0: no loads, 1: load load_val during byte 0, 2: random loads.
   task automatic run_xfer(input bit fm, input int n_bytes, input int extra,
                           input int fixed_mosi, input int load_mode, input logic [7:0] load_val);
      int s0, p0, t0, r0, nb, total;
      logic [7:0] exp_tx, mb, lv;
      logic idl;
      bit do_load;
      idl = fm;
      s0 = n_start[fm]; p0 = n_stop[fm]; t0 = n_txreq[fm]; r0 = n_rx[fm];
      total = n_bytes + ((extra > 0) ? 1 : 0);
      set_cs(fm, 1'b0);
      repeat (HALF) @(negedge clk);
      check_eq("oe_after_cs_fall", get_oe(fm), 1);
      for (int b = 0; b < total; b++) begin
         nb = (b < n_bytes) ? 8 : extra;
         exp_tx = tx_buf_m[fm];
         mb = (fixed_mosi >= 0) ? fixed_mosi[7:0] : 8'($urandom_range(0, 255));
         for (int i = 0; i < nb; i++) begin
            set_mosi(fm, mb[7-i]);
            repeat (HALF) @(negedge clk);
            check_eq($sformatf("miso_b%0d_bit%0d", b, 7 - i), get_miso(fm), exp_tx[7-i]);
            if (nb == 8 && i == 7) begin
               exp_q.push_back(mb);
               last_rx_m[fm] = mb;
            end
            set_sck(fm, ~idl);
            do_load = (i == 3) && ((load_mode == 1 && b == 0) ||
                                   (load_mode == 2 && $urandom_range(0, 1) == 1));
            if (do_load) begin
               lv = (load_mode == 1) ? load_val : 8'($urandom_range(0, 255));
               load_tx(fm, lv);
               repeat (HALF - 1) @(negedge clk);
            end else begin
               repeat (HALF) @(negedge clk);
            end
            set_sck(fm, idl);
         end
      end
      repeat (HALF) @(negedge clk);
      set_cs(fm, 1'b1);
      repeat (SYNC + 2) @(negedge clk);
      check_eq("oe_after_cs_rise", get_oe(fm), 0);
      check_eq("miso_after_cs_rise", get_miso(fm), 0);
      repeat (HALF) @(negedge clk);
      check_eq("start_count", n_start[fm] - s0, 1);
      check_eq("stop_count", n_stop[fm] - p0, 1);
      check_eq("tx_req_count", n_txreq[fm] - t0, 1 + n_bytes);
      check_eq("rx_valid_count", n_rx[fm] - r0, n_bytes);
      check_eq("rx_data_hold", get_rx(fm), last_rx_m[fm]);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_r"}, {miso_r, oe_r, bus_r.tx_req, bus_r.rx_valid, bus_r.start,
                             bus_r.stop, bus_r.rx_data}, 0);
      check_eq({tag, "_f"}, {miso_f, oe_f, bus_f.tx_req, bus_f.rx_valid, bus_f.start,
                             bus_f.stop, bus_f.rx_data}, 0);
   endtask

   // Watchdog.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   // Main stimulus.
   initial begin
      int s0, p0, t0, r0;
      bit fm;
      for (int k = 0; k < 2; k++) begin
         n_start[k] = 0; n_stop[k] = 0; n_txreq[k] = 0; n_rx[k] = 0;
         tx_buf_m[k] = 8'h00; last_rx_m[k] = 8'h00;
      end
      sck_r = 1'b0; cs_r = 1'b1; mosi_r = 1'b0;
      sck_f = 1'b1; cs_f = 1'b1; mosi_f = 1'b0;
      bus_r.tx_data = 8'h00; bus_r.tx_load = 1'b0;
      bus_f.tx_data = 8'h00; bus_f.tx_load = 1'b0;
      #2;
      check_outputs_zero("reset_outputs");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Single byte, RISING.
      load_tx(0, 8'hA5);
      run_xfer(0, 1, 0, 8'h3C, 0, 8'h00);
      // Two-byte burst with a mid-byte load.
      load_tx(0, 8'hC3);
      run_xfer(0, 2, 0, -1, 1, 8'h5A);
      // No reload between bytes: same byte retransmitted.
      load_tx(0, 8'h81);
      run_xfer(0, 2, 0, -1, 0, 8'h00);
      // Abort after five bits.
      run_xfer(0, 0, 5, -1, 0, 8'h00);
      // CS pulse with no SCK edges.
      run_xfer(0, 0, 0, -1, 0, 8'h00);
      // FALLING sample edge.
      load_tx(1, 8'h0F);
      run_xfer(1, 1, 0, 8'hF0, 0, 8'h00);

      // Reset in the middle of a byte.
      load_tx(0, 8'h77);
      s0 = n_start[0]; p0 = n_stop[0]; t0 = n_txreq[0]; r0 = n_rx[0];
      set_cs(0, 1'b0);
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         set_mosi(0, 1'b1);
         set_sck(0, 1'b1);
         repeat (HALF) @(negedge clk);
         set_sck(0, 1'b0);
         repeat (HALF) @(negedge clk);
      end
      set_sck(0, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("reset_mid_byte");
      set_cs(0, 1'b1);
      set_sck(0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tx_buf_m[k] = 8'h00;
         last_rx_m[k] = 8'h00;
      end
      repeat (HALF) @(negedge clk);
      check_eq("rst_start_count", n_start[0] - s0, 1);
      check_eq("rst_stop_count", n_stop[0] - p0, 0);
      check_eq("rst_tx_req_count", n_txreq[0] - t0, 1);
      check_eq("rst_rx_count", n_rx[0] - r0, 0);
      run_xfer(0, 1, 0, -1, 0, 8'h00);

      // Randomized traffic on both instances.
      for (int k = 0; k < 20; k++) begin
         fm = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) load_tx(fm, 8'($urandom_range(0, 255)));
         run_xfer(fm, $urandom_range(0, 3), $urandom_range(0, 7), -1, 2, 8'h00);
      end

      check_eq("rx_queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
